vxe_mem_responder: RTL and testbench
====================================

// Module: vxe_mem_responder
// PURPOSE
//  Memory-side responder for the VxE memory request/response protocol; the far end of the CU fetch unit.
//  Pops request vectors (rqa) and write data (rqd) from its input FIFOs and services them from a local 64-bit word RAM.
//  Pushes response status (rss) and read data (rsd) into output FIFOs, strictly in request order.
//  Serves as a local instruction/data memory for CU bring-up and as a bench memory model.
// PARAMETERS
//  MEM_AW    10  RAM address width in 64-bit words; the RAM holds 2^MEM_AW words.
//  RO_WORDS  0   Words [0, RO_WORDS) are write-protected; 0 disables protection.
// PORTS
//  clk        in   1   clock
//  nrst       in   1   asynchronous active-low reset
//  i_rqa_vld  in   1   request FIFO not empty
//  i_rqa      in   44  request: [43:38] txnid, [37] rnw, [36:0] word address
//  o_rqa_rd   out  1   request FIFO pop; i_rqa sampled in the same cycle
//  i_rqd_vld  in   1   write data FIFO not empty
//  i_rqd      in   64  write data word
//  o_rqd_rd   out  1   write data FIFO pop; i_rqd sampled in the same cycle
//  i_rss_rdy  in   1   response status FIFO can accept
//  o_rss      out  9   response status: [8:3] txnid, [2] rnw, [1:0] err
//  o_rss_wr   out  1   response status push
//  i_rsd_rdy  in   1   response data FIFO can accept
//  o_rsd      out  64  response data (read responses only)
//  o_rsd_wr   out  1   response data push
//  o_busy     out  1   FSM not IDLE, or i_rqa_vld high
// BEHAVIOUR
//  Reset: all outputs 0 and FSM in IDLE; RAM contents are not reset. Reset mid-transaction abandons it; no response is issued.
//  Handshakes:
//   - Pop: o_rqa_rd and o_rqd_rd are registered one-cycle pulses, issued only while the matching _vld is high.
//   - Push: a transfer occurs in each cycle where _wr && _rdy. o_rss/o_rsd and the _wr flags hold stable until that transfer.
//   - Push channels are independent: each _wr flag drops in the cycle after its own transfer.
//  One transaction in flight. FSM states:
//   - IDLE: on i_rqa_vld, pulse o_rqa_rd, latch the request -> DEC.
//   - DEC, address range check (range := addr < 2^MEM_AW; upper address bits are not aliased):
//     - read, in range: issue the synchronous RAM read -> RDAT.
//     - read, out of range: err=2'b01, o_rsd=0 -> RESP.
//     - write: -> WDAT.
//   - WDAT: wait for i_rqd_vld, pulse o_rqd_rd, then:
//     - out of range: err=2'b01, RAM unchanged.
//     - in range and addr < RO_WORDS: err=2'b10, RAM unchanged.
//     - otherwise: RAM[addr] written, err=2'b00.
//     -> RESP. The rqd word is always consumed, so the rqd stream stays aligned with requests.
//   - RDAT: latch RAM output into o_rsd, err=2'b00 -> RESP.
//   - RESP: o_rss_wr=1 for every transaction; o_rsd_wr=1 for reads only (including errored reads). When every raised flag has transferred -> IDLE.
//  Response content: o_rss = {latched txnid, latched rnw, err}.
//  Latency, with C = the o_rqa_rd cycle and ready outputs:
//   - in-range read: o_rss_wr/o_rsd_wr first high at C+3.
//   - errored read: first high at C+2.
//   - write: first high 1 cycle after the o_rqd_rd cycle.
//  Next request pop: no earlier than the cycle after the final push transfer. No pop is issued while in RESP.
//  Read after write to the same address returns the new data (requests are serialised).
//  err encoding: 2'b00 ok, 2'b01 decode error, 2'b10 write-protect, 2'b11 reserved (never generated).
// TESTING
//  - Read in range: preload RAM[5]=64'hDEAD_BEEF_0123_4567; rqa {txnid=6'h11, rnw=1, addr=5}, both rdy high
//    -> rss=9'h08C (txnid 11, rnw 1, err 0) and rsd=DEAD_BEEF_0123_4567 at C+3, each _wr high for one cycle.
//  - Write then read: write addr 3, data 64'h1 (txnid 2), then read addr 3 (txnid 3)
//    -> rss {2,0,00}, then rss {3,1,00} with rsd=1; RAM[3]=1.
//  - Out of range, MEM_AW=10: read addr 37'h400 -> err=01, rsd=0.
//  - Out of range, MEM_AW=10: write addr 37'h400 -> err=01, one rqd word popped, RAM unchanged.
//  - Write protect, RO_WORDS=4: write addr 2 -> err=10, RAM[2] unchanged, o_rqd_rd pulsed once.
//  - Independent backpressure: hold i_rsd_rdy low for 5 cycles while i_rss_rdy is high
//    -> rss pushed once, o_rsd_wr and o_rsd held stable, o_rqa_rd stays low until rsd is pushed.
//  - Reset mid-operation: 4 queued reads, assert nrst low during RDAT of the 2nd
//    -> all outputs 0 immediately; after release, restarts from IDLE at the 3rd request.

Source files
------------

// File: rtl/vxe_mem_responder_if.sv
// vxe_mem_responder_if
// Bundles the four FIFO-facing channels of the VxE memory responder.
// Signal names are from the responder's point of view (i_ = into it, o_ = out of it).
//   rqa : request vectors in, {txnid[5:0], rnw, word address[36:0]}, popped by o_rqa_rd
//   rqd : write data words in, popped by o_rqd_rd
//   rss : response status out, {txnid, rnw, err[1:0]}, pushed by o_rss_wr when i_rss_rdy
//   rsd : response read data out, pushed by o_rsd_wr when i_rsd_rdy
// Modports: slave = the responder, master = whoever owns the FIFOs (bench or fabric).
interface vxe_mem_responder_if;
   logic        i_rqa_vld;
   logic [43:0] i_rqa;
   logic        o_rqa_rd;
   logic        i_rqd_vld;
   logic [63:0] i_rqd;
   logic        o_rqd_rd;
   logic        i_rss_rdy;
   logic [8:0]  o_rss;
   logic        o_rss_wr;
   logic        i_rsd_rdy;
   logic [63:0] o_rsd;
   logic        o_rsd_wr;

   modport slave (
      input  i_rqa_vld, i_rqa, i_rqd_vld, i_rqd, i_rss_rdy, i_rsd_rdy,
      output o_rqa_rd, o_rqd_rd, o_rss, o_rss_wr, o_rsd, o_rsd_wr
   );

   modport master (
      output i_rqa_vld, i_rqa, i_rqd_vld, i_rqd, i_rss_rdy, i_rsd_rdy,
      input  o_rqa_rd, o_rqd_rd, o_rss, o_rss_wr, o_rsd, o_rsd_wr
   );
endinterface

// File: rtl/vxe_mem_responder.sv
// vxe_mem_responder
// Memory-side responder for the VxE request/response protocol. Pops one request
// at a time, services it from a local RAM of 2^MEM_AW 64-bit words and pushes
// the status (and, for reads, the data) back in request order.
// Ports:
//   clk, nrst : clock and asynchronous active-low reset
//   bus       : slave side of vxe_mem_responder_if (rqa/rqd pops, rss/rsd pushes)
//   o_busy    : FSM not idle, or a request is waiting
// Parameters:
//   MEM_AW    : RAM address width in words; higher addresses get a decode error
//   RO_WORDS  : words [0, RO_WORDS) reject writes with err 2'b10
module vxe_mem_responder #(
   parameter int MEM_AW   = 10,
   parameter int RO_WORDS = 0
) (
   input  logic               clk,
   input  logic               nrst,
   vxe_mem_responder_if.slave bus,
   output logic               o_busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEC,
      ST_WDAT,
      ST_RDAT,
      ST_RESP
   } state_t;

   localparam logic [36:0] MEM_WORDS = 37'(1) << MEM_AW;
   localparam logic [36:0] RO_LIMIT  = 37'(RO_WORDS);

   state_t      state_q, state_d;
   logic        rqa_rd_q, rqa_rd_d;
   logic        rqd_rd_q, rqd_rd_d;
   logic [5:0]  txnid_q, txnid_d;
   logic        rnw_q, rnw_d;
   logic [36:0] addr_q, addr_d;
   logic [1:0]  err_q, err_d;
   logic        rss_wr_q, rss_wr_d;
   logic        rsd_wr_q, rsd_wr_d;
   logic [63:0] rsd_q, rsd_d;
   logic        busy_q, busy_d;

   logic [63:0]       mem [0:(1 << MEM_AW) - 1];
   logic [63:0]       ram_rdata;
   logic              mem_we;
   logic              mem_re;
   logic              in_range;
   logic              protected_addr;
   logic [MEM_AW-1:0] ram_idx;

   // Upper address bits are compared, not dropped, so nothing aliases into the RAM.
   assign in_range       = addr_q < MEM_WORDS;
   assign protected_addr = addr_q < RO_LIMIT;
   assign ram_idx        = addr_q[MEM_AW-1:0];

   // Word RAM with a one-cycle synchronous read port. Contents survive reset so
   // a preloaded image stays valid across a CU reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ram_idx] <= bus.i_rqd;
      end
      if (mem_re) begin
         ram_rdata <= mem[ram_idx];
      end
   end

   // Next-state and output logic. Pops are registered pulses: the FSM raises the
   // pulse one cycle, and the pulse cycle itself is where the FIFO head is used.
   // In RESP each push flag drops on its own transfer; IDLE is reached only when
   // both have gone, which keeps responses strictly in request order.
   always_comb begin
      state_d  = state_q;
      rqa_rd_d = 1'b0;
      rqd_rd_d = 1'b0;
      txnid_d  = txnid_q;
      rnw_d    = rnw_q;
      addr_d   = addr_q;
      err_d    = err_q;
      rss_wr_d = rss_wr_q;
      rsd_wr_d = rsd_wr_q;
      rsd_d    = rsd_q;
      mem_we   = 1'b0;
      mem_re   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rqa_rd_q) begin
               txnid_d = bus.i_rqa[43:38];
               rnw_d   = bus.i_rqa[37];
               addr_d  = bus.i_rqa[36:0];
               state_d = ST_DEC;
            end else if (bus.i_rqa_vld) begin
               rqa_rd_d = 1'b1;
            end
         end
         ST_DEC: begin
            if (rnw_q) begin
               if (in_range) begin
                  mem_re  = 1'b1;
                  state_d = ST_RDAT;
               end else begin
                  err_d    = 2'b01;
                  rsd_d    = '0;
                  rss_wr_d = 1'b1;
                  rsd_wr_d = 1'b1;
                  state_d  = ST_RESP;
               end
            end else begin
               state_d = ST_WDAT;
            end
         end
         ST_WDAT: begin
            if (rqd_rd_q) begin
               if (!in_range) begin
                  err_d = 2'b01;
               end else if (protected_addr) begin
                  err_d = 2'b10;
               end else begin
                  err_d  = 2'b00;
                  mem_we = 1'b1;
               end
               rss_wr_d = 1'b1;
               state_d  = ST_RESP;
            end else if (bus.i_rqd_vld) begin
               rqd_rd_d = 1'b1;
            end
         end
         ST_RDAT: begin
            rsd_d    = ram_rdata;
            err_d    = 2'b00;
            rss_wr_d = 1'b1;
            rsd_wr_d = 1'b1;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (rss_wr_q && bus.i_rss_rdy) begin
               rss_wr_d = 1'b0;
            end
            if (rsd_wr_q && bus.i_rsd_rdy) begin
               rsd_wr_d = 1'b0;
            end
            if (!rss_wr_d && !rsd_wr_d) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) || bus.i_rqa_vld;
   end

   // State and output registers. Busy is registered so every output reads 0
   // while reset is held, even with requests waiting.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         rqa_rd_q <= 1'b0;
         rqd_rd_q <= 1'b0;
         txnid_q  <= '0;
         rnw_q    <= 1'b0;
         addr_q   <= '0;
         err_q    <= 2'b00;
         rss_wr_q <= 1'b0;
         rsd_wr_q <= 1'b0;
         rsd_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rqa_rd_q <= rqa_rd_d;
         rqd_rd_q <= rqd_rd_d;
         txnid_q  <= txnid_d;
         rnw_q    <= rnw_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
         rss_wr_q <= rss_wr_d;
         rsd_wr_q <= rsd_wr_d;
         rsd_q    <= rsd_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.o_rqa_rd = rqa_rd_q;
   assign bus.o_rqd_rd = rqd_rd_q;
   assign bus.o_rss    = {txnid_q, rnw_q, err_q};
   assign bus.o_rss_wr = rss_wr_q;
   assign bus.o_rsd    = rsd_q;
   assign bus.o_rsd_wr = rsd_wr_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_vxe_mem_responder.sv
// tb_vxe_mem_responder
// Bench for vxe_mem_responder. The bench owns models of the rqa/rqd FIFOs and a
// word-level memory model; every queued request gets its expected response
// computed up front, in order, from the addressing/protection rules. One compare
// task runs on every falling edge and checks pops, push values, first-push
// latency, hold-under-backpressure and busy against that model. Directed cases
// pin the model with hand-computed literals; a random phase follows.
module tb_vxe_mem_responder;

   localparam int MEM_AW   = 10;
   localparam int RO_WORDS = 4;

   typedef struct {
      logic [8:0]  rss;
      bit          isRead;
      bit          rsdKnown;
      logic [63:0] rsd;
      int          kind;
   } exp_t;

   typedef struct {
      logic [43:0] req;
      int          readyAt;
   } rqa_ent_t;

   typedef struct {
      logic [63:0] data;
      int          readyAt;
   } rqd_ent_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic busy;

   vxe_mem_responder_if bus ();

   vxe_mem_responder #(
      .MEM_AW  (MEM_AW),
      .RO_WORDS(RO_WORDS)
   ) dut (
      .clk   (clk),
      .nrst  (nrst),
      .bus   (bus),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   rqa_ent_t    rqaQ[$];
   rqd_ent_t    rqdQ[$];
   exp_t        expQ[$];
   logic [63:0] memModel[int];
   logic [8:0]  gotRss[$];
   logic [63:0] gotRsd[$];

   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   nextReady = 0;
   int   totalPops = 0;
   bit   inflight = 1'b0;
   exp_t cur;
   int   popCycle = 0;
   int   rqdCycle = 0;
   int   curRqdPops = 0;
   bit   rssDone, rssSeen, rsdDone, rsdSeen;
   bit   prevRssHold = 1'b0;
   bit   prevRsdHold = 1'b0;
   logic [8:0]  prevRss;
   logic [63:0] prevRsd;
   bit   popRqaPending = 1'b0;
   bit   popRqdPending = 1'b0;
   bit   rdyRandom = 1'b0;
   bit   rssRdyForce = 1'b1;
   bit   rsdRdyForce = 1'b1;

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: what a request must produce, from the address map alone.
   task automatic modelTxn(input logic [43:0] req, input logic [63:0] data, output exp_t e);
      logic [36:0] addr;
      bit          rnw;
      bit          inRange;
      bit          prot;
      logic [1:0]  err;
      addr    = req[36:0];
      rnw     = req[37];
      inRange = longint'(addr) < (longint'(1) << MEM_AW);
      prot    = longint'(addr) < longint'(RO_WORDS);
      err     = 2'b00;
      e.isRead   = rnw;
      e.rsdKnown = 1'b1;
      e.rsd      = '0;
      if (rnw) begin
         if (inRange) begin
            e.kind = 0;
            if (memModel.exists(int'(addr))) e.rsd = memModel[int'(addr)];
            else e.rsdKnown = 1'b0;
         end else begin
            e.kind = 1;
            err    = 2'b01;
         end
      end else begin
         e.kind = 2;
         if (!inRange) err = 2'b01;
         else if (prot) err = 2'b10;
         else memModel[int'(addr)] = data;
      end
      e.rss = {req[43:38], rnw, err};
   endtask

   // Queue one request (and its write word) into the FIFO models.
   task automatic applyStimulus(input logic [5:0] txnid, input logic rnw, input logic [36:0] addr,
                                input logic [63:0] data, input int gap);
      rqa_ent_t a;
      rqd_ent_t d;
      exp_t     e;
      nextReady = ((nextReady > cyc) ? nextReady : cyc) + gap;
      a.req     = {txnid, rnw, addr};
      a.readyAt = nextReady;
      rqaQ.push_back(a);
      if (!rnw) begin
         d.data    = data;
         d.readyAt = nextReady + int'($urandom_range(0, 6));
         rqdQ.push_back(d);
      end
      modelTxn(a.req, data, e);
      expQ.push_back(e);
   endtask

   task automatic driveInputs();
      bus.i_rqa_vld = (rqaQ.size() > 0) && (cyc >= rqaQ[0].readyAt);
      bus.i_rqa     = (rqaQ.size() > 0) ? rqaQ[0].req : '0;
      bus.i_rqd_vld = (rqdQ.size() > 0) && (cyc >= rqdQ[0].readyAt);
      bus.i_rqd     = (rqdQ.size() > 0) ? rqdQ[0].data : '0;
      if (rdyRandom) begin
         bus.i_rss_rdy = ($urandom_range(0, 9) < 7);
         bus.i_rsd_rdy = ($urandom_range(0, 9) < 7);
      end else begin
         bus.i_rss_rdy = rssRdyForce;
         bus.i_rsd_rdy = rsdRdyForce;
      end
   endtask

   // Just after a rising edge: retire FIFO heads popped in the previous cycle.
   task automatic advanceEdge();
      @(posedge clk);
      #1;
      cyc++;
      if (popRqaPending && rqaQ.size() > 0) void'(rqaQ.pop_front());
      if (popRqdPending && rqdQ.size() > 0) void'(rqdQ.pop_front());
      popRqaPending = 1'b0;
      popRqdPending = 1'b0;
      driveInputs();
   endtask

   // Per-cycle compare against the model, sampled mid-cycle.
   task automatic compareCycle();
      int expCyc;
      if (bus.o_rqa_rd) begin
         checkOutput(bus.i_rqa_vld && !inflight, "rqa_pop_legal",
                     64'({inflight, bus.i_rqa_vld}), 64'(2'b01));
         totalPops++;
         popRqaPending = 1'b1;
         if (expQ.size() > 0) cur = expQ.pop_front();
         inflight   = 1'b1;
         popCycle   = cyc;
         rssDone    = 1'b0;
         rssSeen    = 1'b0;
         rsdDone    = !cur.isRead;
         rsdSeen    = 1'b0;
         curRqdPops = 0;
      end
      if (bus.o_rqd_rd) begin
         checkOutput(bus.i_rqd_vld && inflight && cur.kind == 2 && curRqdPops == 0, "rqd_pop_legal",
                     64'({bus.i_rqd_vld, inflight, curRqdPops[3:0]}), 64'({1'b1, 1'b1, 4'd0}));
         curRqdPops++;
         rqdCycle      = cyc;
         popRqdPending = 1'b1;
      end
      if (inflight) checkOutput(busy == 1'b1, "busy_inflight", 64'(busy), 64'(1));
      expCyc = (cur.kind == 0) ? popCycle + 3 : (cur.kind == 1) ? popCycle + 2 : rqdCycle + 1;

      if (prevRssHold)
         checkOutput(bus.o_rss_wr && bus.o_rss == prevRss, "rss_hold",
                     64'({bus.o_rss_wr, bus.o_rss}), 64'({1'b1, prevRss}));
      if (bus.o_rss_wr) begin
         checkOutput(inflight && !rssDone, "rss_wr_legal", 64'({inflight, rssDone}), 64'(2'b10));
         if (!rssSeen) begin
            rssSeen = 1'b1;
            checkOutput(cyc == expCyc, "rss_latency", 64'(cyc - popCycle), 64'(expCyc - popCycle));
         end
         checkOutput(bus.o_rss == cur.rss, "rss_value", 64'(bus.o_rss), 64'(cur.rss));
         if (bus.i_rss_rdy) begin
            rssDone = 1'b1;
            gotRss.push_back(bus.o_rss);
         end
      end
      prevRssHold = bus.o_rss_wr && !bus.i_rss_rdy;
      prevRss     = bus.o_rss;

      if (prevRsdHold)
         checkOutput(bus.o_rsd_wr && bus.o_rsd == prevRsd, "rsd_hold", bus.o_rsd, prevRsd);
      if (bus.o_rsd_wr) begin
         checkOutput(inflight && cur.isRead && !rsdDone, "rsd_wr_legal",
                     64'({inflight, cur.isRead, rsdDone}), 64'(3'b110));
         if (!rsdSeen) begin
            rsdSeen = 1'b1;
            checkOutput(cyc == expCyc, "rsd_latency", 64'(cyc - popCycle), 64'(expCyc - popCycle));
         end
         if (cur.rsdKnown) checkOutput(bus.o_rsd == cur.rsd, "rsd_value", bus.o_rsd, cur.rsd);
         if (bus.i_rsd_rdy) begin
            rsdDone = 1'b1;
            gotRsd.push_back(bus.o_rsd);
         end
      end
      prevRsdHold = bus.o_rsd_wr && !bus.i_rsd_rdy;
      prevRsd     = bus.o_rsd;

      if (inflight && rssDone && rsdDone) begin
         inflight = 1'b0;
         if (cur.kind == 2) checkOutput(curRqdPops == 1, "rqd_pop_count", 64'(curRqdPops), 64'(1));
      end
   endtask

   task automatic stepCycle();
      advanceEdge();
      @(negedge clk);
      compareCycle();
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while ((inflight || expQ.size() > 0) && n < budget) begin
         stepCycle();
         n++;
      end
      checkOutput(n < budget, "drain_in_budget", 64'(n), 64'(budget));
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({bus.o_rqa_rd, bus.o_rqd_rd, bus.o_rss, bus.o_rss_wr, bus.o_rsd_wr, busy} == '0,
                  name, 64'({bus.o_rqa_rd, bus.o_rqd_rd, bus.o_rss, bus.o_rss_wr, bus.o_rsd_wr, busy}), 64'(0));
      checkOutput(bus.o_rsd == '0, {name, "_rsd"}, bus.o_rsd, 64'(0));
   endtask

   initial begin
      int startPops;
      int n;
      logic [36:0] addr;
      bus.i_rqa_vld = 1'b0;
      bus.i_rqa     = '0;
      bus.i_rqd_vld = 1'b0;
      bus.i_rqd     = '0;
      bus.i_rss_rdy = 1'b1;
      bus.i_rsd_rdy = 1'b1;
      #2;
      checkAllZero("reset_outputs");
      repeat (3) @(negedge clk);
      nrst = 1'b1;

      $display("[TB] directed: read in range");
      gotRss.delete(); gotRsd.delete();
      applyStimulus(6'h10, 1'b0, 37'd5, 64'hDEAD_BEEF_0123_4567, 0);
      applyStimulus(6'h11, 1'b1, 37'd5, 64'h0, 0);
      waitIdle(100);
      checkOutput(gotRss[1] == 9'h08C, "lit_read_rss", 64'(gotRss[1]), 64'(9'h08C));
      checkOutput(gotRsd[0] == 64'hDEAD_BEEF_0123_4567, "lit_read_rsd", gotRsd[0], 64'hDEAD_BEEF_0123_4567);

      $display("[TB] directed: write then read");
      gotRss.delete(); gotRsd.delete();
      applyStimulus(6'h02, 1'b0, 37'd9, 64'h1, 0);
      applyStimulus(6'h03, 1'b1, 37'd9, 64'h0, 0);
      waitIdle(100);
      checkOutput(gotRss[0] == 9'h010, "lit_wr_rss", 64'(gotRss[0]), 64'(9'h010));
      checkOutput(gotRss[1] == 9'h01C, "lit_rd_rss", 64'(gotRss[1]), 64'(9'h01C));
      checkOutput(gotRsd[0] == 64'h1, "lit_rd_rsd", gotRsd[0], 64'h1);

      $display("[TB] directed: out-of-range read and write");
      gotRss.delete(); gotRsd.delete();
      applyStimulus(6'h04, 1'b1, 37'h400, 64'h0, 0);
      applyStimulus(6'h12, 1'b0, 37'd4, 64'hA5A5_A5A5_5A5A_5A5A, 0);
      applyStimulus(6'h05, 1'b0, 37'h404, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      applyStimulus(6'h06, 1'b1, 37'd4, 64'h0, 0);
      waitIdle(150);
      checkOutput(gotRss[0] == 9'h025, "lit_oob_rd_rss", 64'(gotRss[0]), 64'(9'h025));
      checkOutput(gotRsd[0] == 64'h0, "lit_oob_rd_rsd", gotRsd[0], 64'h0);
      checkOutput(gotRss[2] == 9'h029, "lit_oob_wr_rss", 64'(gotRss[2]), 64'(9'h029));
      checkOutput(gotRsd[1] == 64'hA5A5_A5A5_5A5A_5A5A, "lit_no_alias", gotRsd[1], 64'hA5A5_A5A5_5A5A_5A5A);

      $display("[TB] directed: write protect");
      gotRss.delete(); gotRsd.delete();
      applyStimulus(6'h07, 1'b0, 37'd2, 64'h1234, 0);
      waitIdle(100);
      checkOutput(gotRss[0] == 9'h03A, "lit_wp_rss", 64'(gotRss[0]), 64'(9'h03A));

      $display("[TB] directed: rsd backpressure");
      gotRss.delete(); gotRsd.delete();
      rsdRdyForce = 1'b0;
      applyStimulus(6'h08, 1'b1, 37'd5, 64'h0, 0);
      applyStimulus(6'h09, 1'b1, 37'd9, 64'h0, 0);
      n = 0;
      while (!bus.o_rsd_wr && n < 50) begin
         stepCycle();
         n++;
      end
      checkOutput(n < 50, "bp_rsd_wr_seen", 64'(n), 64'(50));
      repeat (5) stepCycle();
      checkOutput(gotRss.size() == 1, "bp_rss_once", 64'(gotRss.size()), 64'(1));
      checkOutput(bus.o_rsd_wr == 1'b1, "bp_rsd_held", 64'(bus.o_rsd_wr), 64'(1));
      rsdRdyForce = 1'b1;
      waitIdle(100);
      checkOutput(gotRsd[0] == 64'hDEAD_BEEF_0123_4567, "bp_rsd_value", gotRsd[0], 64'hDEAD_BEEF_0123_4567);

      $display("[TB] directed: reset mid-operation");
      gotRss.delete(); gotRsd.delete();
      applyStimulus(6'h20, 1'b1, 37'd5, 64'h0, 0);
      applyStimulus(6'h21, 1'b1, 37'd9, 64'h0, 0);
      applyStimulus(6'h22, 1'b1, 37'd4, 64'h0, 0);
      applyStimulus(6'h23, 1'b1, 37'd5, 64'h0, 0);
      startPops = totalPops;
      n = 0;
      while (totalPops < startPops + 2 && n < 100) begin
         stepCycle();
         n++;
      end
      checkOutput(n < 100, "rst_second_pop", 64'(n), 64'(100));
      stepCycle();
      advanceEdge();
      nrst = 1'b0;
      #1;
      checkAllZero("midop_reset_outputs");
      inflight    = 1'b0;
      prevRssHold = 1'b0;
      prevRsdHold = 1'b0;
      @(negedge clk);
      compareCycle();
      repeat (2) stepCycle();
      nrst = 1'b1;
      waitIdle(100);
      checkOutput(gotRss.size() == 3, "rst_resp_count", 64'(gotRss.size()), 64'(3));
      checkOutput(gotRss[0] == 9'h104, "rst_first_rss", 64'(gotRss[0]), 64'(9'h104));
      checkOutput(gotRss[1] == 9'h114, "rst_third_rss", 64'(gotRss[1]), 64'(9'h114));

      $display("[TB] random phase");
      rdyRandom = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: addr = 37'($urandom_range(0, 15));
            6:       addr = 37'd1023;
            7:       addr = 37'd1024 + 37'($urandom_range(0, 15));
            8:       addr = {5'($urandom), 32'($urandom)};
            default: addr = 37'($urandom_range(0, 3));
         endcase
         applyStimulus(6'($urandom), 1'($urandom), addr, {$urandom, $urandom}, int'($urandom_range(0, 8)));
      end
      waitIdle(6000);

      rdyRandom = 1'b0;
      repeat (3) stepCycle();
      checkOutput(busy == 1'b0, "idle_not_busy", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
